// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for the shared 16-bit ALU: grant, one-cycle issue, registered result/flags response.
// Optional ALU_SHARE_ARBITER_PERF_EN adds grant and conflict counters.
module alu_share_arbiter #(
  parameter int          PRIORITY = 0,
  parameter logic [3:0]  IDLE_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_flags,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_result,
  input  logic [2:0]  alu_flags
`ifdef ALU_SHARE_ARBITER_PERF_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
  output logic [15:0] conflict_cnt
`endif
);

  // Handshakes: a request transfers on a cycle where reqN_valid && reqN_ready;
  // a response transfers on a cycle where rspN_valid && rspN_ready.
  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   rr_ptr;
  logic   grant;
  logic   win;

  always_comb begin
    grant      = 1'b0;
    win        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_opcode = IDLE_OP;
    alu_in1    = 16'h0000;
    alu_in2    = 16'h0000;
    state_nxt  = state;
    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          grant = 1'b1;
          // On a tie, round-robin picks the requester not granted last.
          if (req0_valid && req1_valid) win = (PRIORITY != 0) ? 1'b0 : ~rr_ptr;
          else                          win = req1_valid;
          req0_ready = ~win;
          req1_ready = win;
          alu_opcode = win ? req1_op : req0_op;
          alu_in1    = win ? req1_a  : req0_a;
          alu_in2    = win ? req1_b  : req0_b;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        if ((!owner && rsp0_ready) || (owner && rsp1_ready)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b1;
      rsp_data  <= 16'h0000;
      rsp_flags <= 3'b000;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner     <= win;
        rr_ptr    <= win;
        rsp_data  <= alu_result;
        rsp_flags <= alu_flags;
      end
    end
  end

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;

`ifdef ALU_SHARE_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0   <= 16'h0000;
      grant_cnt1   <= 16'h0000;
      conflict_cnt <= 16'h0000;
    end else begin
      if (grant && !win) grant_cnt0 <= grant_cnt0 + 16'h0001;
      if (grant && win)  grant_cnt1 <= grant_cnt1 + 16'h0001;
      if (state == IDLE && req0_valid && req1_valid) conflict_cnt <= conflict_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 16-bit ALU between two requesters: req0 is the pipeline execute stage, req1 is the auxiliary/debug engine.
- Each requester issues {opcode, operand A, operand B} over a valid/ready handshake.
- The arbiter grants one requester, drives the ALU ports for exactly one cycle, and registers ALU result and VNZ flags.
- It returns the registered result to the granted requester over a valid/ready response channel.

Parameters:
- PRIORITY, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (req0 always wins).
- IDLE_OP, 4'hF, opcode driven to the ALU when no issue is in progress; must be an opcode that writes no flags.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (grant)
- req0_op / req1_op  in  4  ALU opcode
- req0_a / req1_a  in  16  operand 1
- req0_b / req1_b  in  16  operand 2
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester consumes the result
- rsp_data  out  16  registered ALU result
- rsp_flags  out  3  registered flags {V,N,Z}
- alu_opcode  out  4  to ALU Opcode
- alu_in1  out  16  to ALU operand 1
- alu_in2  out  16  to ALU operand 2
- alu_result  in  16  from ALU output
- alu_flags  in  3  from ALU F (VNZ, already flag-enable-resolved)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state=IDLE, rsp0_valid=rsp1_valid=0, rsp_data=0, rsp_flags=0, rr pointer=1 (so req0 wins the first tie), alu_opcode=IDLE_OP, alu_in1=alu_in2=0.
- Two states, IDLE and RESP. reqN_ready is combinational and asserted only in IDLE for the winner.
- IDLE with no valid:
  - alu_opcode=IDLE_OP, alu_in1=alu_in2=0.
  - IDLE_OP prevents spurious flag writes in the ALU.
- IDLE with any valid, grant chosen as follows:
  - Only one valid: that requester wins.
  - Both valid, PRIORITY=1: req0 wins.
  - Both valid, PRIORITY=0: the requester not granted last wins.
  - Winner's op/a/b are driven onto the ALU combinationally in the same cycle.
  - On the clock edge: alu_result goes to rsp_data, alu_flags goes to rsp_flags, owner is recorded, rr pointer becomes the winner, state becomes RESP.
- RESP:
  - ALU driven with IDLE_OP/0/0.
  - rspN_valid=1 for the owner only; rsp_data and rsp_flags held stable.
  - On rspN_ready, valid drops next cycle and state returns to IDLE.
  - The non-owner's ready input is ignored.
  - No new grant is issued in the same cycle as acceptance.
- Timing:
  - Latency from grant to rsp valid: 1 cycle.
  - Throughput: 1 op per 2 cycles when the responder is ready immediately.
- Flags:
  - rsp_flags reflects ALU F as seen in the issue cycle.
  - For non-flag-writing ops (RED, ROR, PADDSB, LW, SW, LLB, LHB, branches), rsp_flags carries the unchanged prior flags.
- Operand values are passed through unmodified; address scaling and byte merging stay inside the ALU.
- Requests not granted must hold valid and operands stable. The arbiter does not latch unaccepted requests.
- Reset mid-operation:
  - Any pending result is discarded and rsp valids deassert.
  - The requester must reissue.
- Simultaneous rst and rsp_ready: reset wins.
- Starvation bound (PRIORITY=0): under continuous contention, grants alternate 0,1,0,1.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_PERF_EN.
- Defined:
  - Adds outputs grant_cnt0 [15:0] and grant_cnt1 [15:0].
  - Each increments on every grant to its requester and wraps 16'hFFFF to 0.
  - Both cleared by rst.
  - Adds conflict_cnt [15:0], incremented in every IDLE cycle where both valids are high; same wrap and reset rules.
- Undefined: the counters and their ports do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles -> alu_opcode=4'hF every cycle, both rsp_valid=0, rsp_data=0.
- req0 ADD a=16'h7FFF b=16'h0001, rsp0_ready=1 -> req0_ready in cycle 0; cycle 1 shows rsp0_valid=1, rsp_data=16'h8000, rsp_flags=3'b110; IDLE in cycle 2.
- PRIORITY=0, both valid continuously, both rsp_ready=1, 6 requests -> grant order 0,1,0,1,0,1, one grant every 2 cycles.
- PRIORITY=1, both valid for 3 grants -> all three to req0; req1_ready stays 0.
- req1 SUB a=16'h0005 b=16'h0005, hold rsp1_ready=0 for 4 cycles -> rsp1_valid and rsp_data=0, flags=3'b001 held; req0_valid meanwhile is not granted until 1 cycle after rsp1_ready.
- rst asserted while in RESP -> next cycle rsp valids=0, state IDLE, and with both valids high req0 wins first (pointer reset).
